// File: rtl/cdc_handshake_tx_pkg.sv
// Shared constants and FSM encoding for the four-phase req/ack CDC handshake.
package cdc_handshake_tx_pkg;

    // Defaults shared with the matching receive-side block
    localparam int DEF_DATA_W         = 8;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_WAIT_ACK_HI = 2'd1,
        ST_WAIT_ACK_LO = 2'd2
    } hs_state_e;

endpackage

// File: rtl/sync_n_stage.sv
// N-flop level synchroniser with asynchronous active-low reset.
module sync_n_stage #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_ff;

    // Shift the asynchronous level through the chain; the last flop is the safe copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_ff <= '0;
        else        sync_ff <= {sync_ff[STAGES-2:0], d};
    end

    assign q = sync_ff[STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack CDC handshake with synchronised ack
// and a per-wait-state timeout that abandons a stuck handshake.
module cdc_handshake_tx
    import cdc_handshake_tx_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int TO_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic              xfer_req,
    output logic [DATA_W-1:0] xfer_data,
    input  logic              xfer_ack_async,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr
);

    hs_state_e         state, state_nxt;
    logic [TO_W-1:0]   to_cnt, to_cnt_nxt;
    logic              req_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              err_nxt;
    logic              to_fire;
    logic              to_hit;
    logic              ack_s;

    sync_n_stage #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (xfer_ack_async),
        .q     (ack_s)
    );

    // The counter holds the number of completed cycles in the current wait
    // state, so the edge ending the TIMEOUT_CYCLES-th cycle is where it fires.
    assign to_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state, request/data and timeout decisions; a real ack beats a
    // coincident timeout so a handshake that completes is never flagged.
    always_comb begin
        state_nxt  = state;
        req_nxt    = xfer_req;
        data_nxt   = xfer_data;
        to_cnt_nxt = '0;
        to_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (src_valid) begin
                    data_nxt  = src_data;
                    req_nxt   = 1'b1;
                    state_nxt = ST_WAIT_ACK_HI;
                end
            end
            ST_WAIT_ACK_HI: begin
                if (ack_s) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_WAIT_ACK_LO;
                end else if (to_hit) begin
                    req_nxt   = 1'b0;
                    state_nxt = ST_WAIT_ACK_LO;
                    to_fire   = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            ST_WAIT_ACK_LO: begin
                if (!ack_s) begin
                    state_nxt = ST_IDLE;
                end else if (to_hit) begin
                    state_nxt = ST_IDLE;
                    to_fire   = 1'b1;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                req_nxt   = 1'b0;
            end
        endcase
        // Sticky error: a new timeout wins over a simultaneous clear
        if (to_fire)      err_nxt = 1'b1;
        else if (err_clr) err_nxt = 1'b0;
        else              err_nxt = timeout_err;
    end

    // State, counter and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            to_cnt      <= '0;
            xfer_req    <= 1'b0;
            xfer_data   <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            to_cnt      <= to_cnt_nxt;
            xfer_req    <= req_nxt;
            xfer_data   <= data_nxt;
            timeout_err <= err_nxt;
        end
    end

    // Status decoded from the state register only
    assign src_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);

endmodule

// File: doc/cdc_handshake_tx.md
Name: cdc_handshake_tx

Overview:
Source-side sender of a four-phase req/ack CDC handshake. It accepts a word on a valid/ready interface in the clk domain and launches it on a held-stable data bus with a level req. It then waits for the asynchronous ack from the far domain, synchronising that ack internally. It is the sending end paired with the team's two-flop synchronizer receive path, and carries multi-bit control words safely between domains.

Parameters:
DATA_W, 8, width of transferred word
SYNC_STAGES, 2, flops in the ack synchroniser (legal values 2 or 3)
TIMEOUT_CYCLES, 255, max clk cycles in either wait state before error; 0 disables the timeout
TO_W, 8, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
src_valid  input  1  source has a word
src_data  input  DATA_W  word to send
src_ready  output  1  block can accept a word
xfer_req  output  1  four-phase request level to far domain, registered
xfer_data  output  DATA_W  data to far domain, registered, stable while xfer_req=1
xfer_ack_async  input  1  far-domain ack, asynchronous to clk
busy  output  1  handshake in progress (state != IDLE)
timeout_err  output  1  sticky error flag
err_clr  input  1  clears timeout_err

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, xfer_req=0, xfer_data=0, timeout_err=0, timeout counter=0.
  - All ack synchroniser flops are 0.
  - src_ready=1 once rst_n is high.
- ack_s is xfer_ack_async passed through SYNC_STAGES flops. The FSM uses only ack_s, never the raw input.
- IDLE:
  - src_ready=1.
  - On the clk edge with src_valid=1, capture src_data into xfer_data, set xfer_req=1, go to WAIT_ACK_HI.
  - Latency is 1 cycle from accept to xfer_req high.
- WAIT_ACK_HI:
  - src_ready=0; xfer_req and xfer_data hold.
  - When ack_s=1, set xfer_req=0 and go to WAIT_ACK_LO.
- WAIT_ACK_LO:
  - src_ready=0; xfer_req=0; xfer_data holds its value.
  - When ack_s=0, go to IDLE. src_ready=1 on the following cycle.
- Minimum cycle count: a full transfer is at least 2*SYNC_STAGES+3 cycles accept-to-accept when the far side acks instantly.
- Timeout:
  - The counter resets to 0 on every state change and increments each cycle spent in a wait state.
  - When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0), set timeout_err=1.
  - From WAIT_ACK_HI, drop xfer_req and go to WAIT_ACK_LO.
  - From WAIT_ACK_LO, go to IDLE.
  - The handshake is abandoned; there is no retry.
- timeout_err stays at 1 until err_clr=1. If err_clr and a new timeout occur in the same cycle, the set wins.
- ack_s already high in IDLE (stale far side): a new request is still launched. WAIT_ACK_HI completes on the next sampled ack_s=1, which is allowed. The far side is responsible for protocol order.
- src_valid while busy is ignored; no input buffering.
- Reset mid-handshake: outputs return to their reset values immediately, asynchronously. The far side sees req fall.
- No combinational path from any input to any output. src_ready is decoded from the state register only.

Decomposition:
- Shared package holds:
  - the FSM state enum (IDLE, WAIT_ACK_HI, WAIT_ACK_LO; 2-bit encoding);
  - the default DATA_W and TIMEOUT_CYCLES constants, shared with the matching receive-side block.
- One natural sub-module, sync_n_stage: a parameterised SYNC_STAGES-flop synchroniser with async active-low reset, instantiated for xfer_ack_async.

Test Plan:
1. Basic transfer, with an ack model that raises ack 3 cycles after req rises and drops it 3 cycles after req falls:
   - src_valid=1, src_data=0xA5 in IDLE -> next cycle xfer_req=1, xfer_data=0xA5, src_ready=0.
   - xfer_req falls SYNC_STAGES+1 cycles after ack rises.
   - src_ready=1 after ack falls plus sync delay.
2. Back-to-back: hold src_valid=1 with 0x11 then 0x22 -> 0x22 is accepted only after the first handshake returns to IDLE. xfer_data never changes while xfer_req=1.
3. Timeout: TIMEOUT_CYCLES=16, ack tied 0, send 0x3C -> timeout_err=1 at the 16th wait cycle, xfer_req=0, return to IDLE. A pulse of err_clr=1 clears the flag.
4. Reset mid-handshake: assert rst_n=0 in WAIT_ACK_HI -> xfer_req=0, xfer_data=0, busy=0 without a clk edge. After release, src_ready=1.
5. Glitchy ack: a 1-cycle ack pulse shorter than the sync window -> no state change if it is missed. If it is captured, the FSM advances cleanly to WAIT_ACK_LO with no illegal state.
6. Ignored input: src_valid pulses with 0xFF while busy -> no capture. xfer_data keeps the original word until the next IDLE accept.
